// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// The sequencer state enum, the bus widths and the port indices live here
// so the arbiter, its sequencer and any bench agree on them.
package sram_arb_pkg;

  localparam int SRAM_DQ_W = 16;
  localparam int WORD_W    = 32;

  localparam logic P_MEM  = 1'b0;
  localparam logic P_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LO_SET = 3'd1,
    ST_LO_ACC = 3'd2,
    ST_HI_SET = 3'd3,
    ST_HI_ACC = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // True in the four states that own the SRAM for a halfword cycle.
  function automatic logic is_xfer(state_e s);
    return (s == ST_LO_SET) || (s == ST_LO_ACC) ||
           (s == ST_HI_SET) || (s == ST_HI_ACC);
  endfunction

  // True in the two states that address the high halfword.
  function automatic logic is_hi(state_e s);
    return (s == ST_HI_SET) || (s == ST_HI_ACC);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: two word request ports,
// their completion pulses, the shared read word and the busy flag.
// The requesters hold the master modport, the arbiter the slave modport.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [WORD_W-1:0] addr0;
  logic [WORD_W-1:0] addr1;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [WORD_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata, busy
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata, busy
  );

endinterface

// File: rtl/sram_arbiter_word_seq.sv
// Halfword sequencer: turns one latched 32-bit word request into two
// 16-bit SRAM cycles (low halfword first), owns the SRAM pins, captures
// read data and pulses the done line of the port that was served.
// Every SRAM pin is decoded from the state register and latched request
// only, so no request input reaches a pin combinationally.
module sram_word_seq
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  input  logic                 req_port,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_hw_addr,
  input  logic [WORD_W-1:0]    req_wdata,
  output logic                 busy,
  output logic                 done0,
  output logic                 done1,
  output logic [WORD_W-1:0]    rdata,
  inout  wire  [SRAM_DQ_W-1:0] sram_dq,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n
);

  state_e               state_q;
  state_e               state_d;
  logic                 accept;
  logic                 port_q;
  logic                 wr_q;
  logic [ADDR_W-1:0]    lo_addr_q;
  logic [ADDR_W-1:0]    hi_addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [SRAM_DQ_W-1:0] rd_lo_q;
  logic                 dq_oe;
  logic [SRAM_DQ_W-1:0] dq_out;

  assign accept = (state_q == ST_IDLE) && req_vld;

  // State register; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch which port was granted and the direction on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q <= P_MEM;
      wr_q   <= 1'b0;
    end else if (accept) begin
      port_q <= req_port;
      wr_q   <= req_wr;
    end
  end

  // Latch address and write data; the high halfword address wraps
  // modulo the SRAM size, matching a dropped carry out of the byte address.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_addr_q <= req_hw_addr;
      hi_addr_q <= req_hw_addr + ADDR_W'(1);
      wdata_q   <= req_wdata;
    end
  end

  // Capture the low read halfword on the edge leaving LO_ACC.
  always_ff @(posedge clk) begin
    if ((state_q == ST_LO_ACC) && !wr_q) begin
      rd_lo_q <= sram_dq;
    end
  end

  // The edge leaving HI_ACC both captures the high halfword and enters
  // DONE, so the assembled word is loaded into rdata on that edge; writes
  // leave rdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if ((state_q == ST_HI_ACC) && !wr_q) begin
      rdata <= {sram_dq, rd_lo_q};
    end
  end

  // Next state and state-decoded SRAM strobes, address and dq drive.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done0     = 1'b0;
    done1     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[SRAM_DQ_W-1:0];

    if (is_xfer(state_q)) begin
      sram_oe_n = wr_q;
      dq_oe     = wr_q;
      sram_addr = is_hi(state_q) ? hi_addr_q : lo_addr_q;
      if (is_hi(state_q)) begin
        dq_out = wdata_q[WORD_W-1:SRAM_DQ_W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (req_vld) begin
          state_d = ST_LO_SET;
        end
      end
      ST_LO_SET: state_d = ST_LO_ACC;
      ST_LO_ACC: begin
        state_d   = ST_HI_SET;
        sram_we_n = !wr_q;
      end
      ST_HI_SET: state_d = ST_HI_ACC;
      ST_HI_ACC: begin
        state_d   = ST_DONE;
        sram_we_n = !wr_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done0   = (port_q == P_MEM);
        done1   = (port_q == P_LOAD);
      end
      default: begin
        state_d = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  assign sram_ce_n = !busy;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_dq   = dq_oe ? dq_out : {SRAM_DQ_W{1'bz}};

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a 16-bit asynchronous SRAM.
// Port 0 is the MEM-stage data path, port 1 the program/debug loader.
// This level only picks a winner and muxes its request into the halfword
// sequencer, which samples it while idle.
// Build option SRAM_ARB_RR_EN: round-robin on simultaneous requests
// (last-served pointer, reset to port 1). Without it port 0 always wins
// and port 1 may starve under continuous port-0 traffic.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_arbiter_if.slave        bus,
  inout  wire  [SRAM_DQ_W-1:0] sram_dq,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n
);

  logic              grant_vld;
  logic              grant_port;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_hw_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic              unused_addr;

  assign grant_vld = bus.req0 | bus.req1;

  // Byte-lane bit 0 and address bits above the SRAM range are ignored.
  assign unused_addr = ^{bus.addr0[WORD_W-1:ADDR_W+1], bus.addr0[0],
                         bus.addr1[WORD_W-1:ADDR_W+1], bus.addr1[0]};

`ifdef SRAM_ARB_RR_EN
  logic last_q;

  // Round-robin winner: on contention the port not served last wins.
  always_comb begin
    grant_port = P_MEM;
    if (bus.req0 && bus.req1) begin
      grant_port = ~last_q;
    end else if (bus.req1) begin
      grant_port = P_LOAD;
    end
  end

  // Remember the last served port on every grant taken by the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= P_LOAD;
    end else if (!bus.busy && grant_vld) begin
      last_q <= grant_port;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests.
  always_comb begin
    grant_port = P_MEM;
    if (!bus.req0 && bus.req1) begin
      grant_port = P_LOAD;
    end
  end
`endif

  // Route the winning port's request fields to the sequencer.
  always_comb begin
    sel_wr      = bus.wr0;
    sel_hw_addr = bus.addr0[ADDR_W:1];
    sel_wdata   = bus.wdata0;
    if (grant_port == P_LOAD) begin
      sel_wr      = bus.wr1;
      sel_hw_addr = bus.addr1[ADDR_W:1];
      sel_wdata   = bus.wdata1;
    end
  end

  sram_word_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (grant_vld),
    .req_port    (grant_port),
    .req_wr      (sel_wr),
    .req_hw_addr (sel_hw_addr),
    .req_wdata   (sel_wdata),
    .busy        (bus.busy),
    .done0       (bus.done0),
    .done1       (bus.done1),
    .rdata       (bus.rdata),
    .sram_dq     (sram_dq),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ce_n   (sram_ce_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM device on the pins, a
// halfword-array reference model, and a scoreboard queue of expected
// completions popped by a monitor whenever a done pulse appears.
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W = 18;
  localparam int HW_N   = 1 << ADDR_W;

  typedef struct {
    logic        port;
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  sram_arbiter_if bus();
  wire  [15:0]       sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM device
  logic [15:0] sram_mem [HW_N];
  logic        sram_drv;
  assign sram_drv = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq  = sram_drv ? sram_mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  // Reference model: halfword contents and last-served port
  logic [15:0] ref_hw [int];
  logic        last_srv;
  exp_t        exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] ref_rd(int i);
    return ref_hw.exists(i) ? ref_hw[i] : 16'h0000;
  endfunction

  function automatic int lo_idx(logic [31:0] a);
    logic [31:0] h;
    h = a >> 1;
    return int'(h % 32'(HW_N));
  endfunction

  function automatic int hi_idx(logic [31:0] a);
    logic [31:0] h;
    h = (a >> 1) + 32'd1;
    return int'(h % 32'(HW_N));
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    return {ref_rd(hi_idx(a)), ref_rd(lo_idx(a))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.done0 || bus.done1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {30'd0, bus.done1, bus.done0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_port", {30'd0, bus.done1, bus.done0}, e.port ? 32'd2 : 32'd1);
        if (e.is_rd) check("rdata", bus.rdata, e.data);
      end
    end
  end

  int                ncyc;
  bit                got;
  logic [ADDR_W-1:0] tr_addr [32];
  logic [15:0]       tr_dq   [32];
  logic              tr_we   [32];

  task automatic do_txn(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int drop_at);
    exp_t e;
    e.port  = p;
    e.is_rd = !w;
    e.data  = ref_word(a);
    exp_q.push_back(e);
    last_srv = p;
    if (w) begin
      ref_hw[lo_idx(a)] = d[15:0];
      ref_hw[hi_idx(a)] = d[31:16];
    end
    if (p) begin
      bus.req1 = 1'b1; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
    ncyc = 0;
    got  = 0;
    while (!got && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      tr_addr[ncyc] = sram_addr;
      tr_dq[ncyc]   = sram_dq;
      tr_we[ncyc]   = sram_we_n;
      if (ncyc == drop_at) begin
        if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (p ? bus.done1 : bus.done0) got = 1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("txn_complete", 32'(got), 32'd1);
    check("txn_latency", ncyc, 32'd5);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic        win;
    int          cnt;
    int          we_low;
    logic [31:0] a, a0, a1;

    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    last_srv = 1'b1;
    for (int i = 0; i < HW_N; i++) sram_mem[i] = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   {30'd0, bus.done1, bus.done0}, 32'd0);
    check("rst_rdata",  bus.rdata, 32'd0);
    check("rst_addr",   32'(sram_addr), 32'd0);
    check("rst_we_n",   32'(sram_we_n), 32'd1);
    check("rst_oe_n",   32'(sram_oe_n), 32'd1);
    check("rst_ce_n",   32'(sram_ce_n), 32'd1);
    check("ub_lb",      {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Port 0 write: halfword trace on the pins
    do_txn(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    check("wr_lo_set_addr", 32'(tr_addr[1]), 32'h080);
    check("wr_lo_set_we",   32'(tr_we[1]),   32'd1);
    check("wr_lo_addr",     32'(tr_addr[2]), 32'h080);
    check("wr_lo_dq",       32'(tr_dq[2]),   32'hBEEF);
    check("wr_lo_we",       32'(tr_we[2]),   32'd0);
    check("wr_hi_addr",     32'(tr_addr[4]), 32'h081);
    check("wr_hi_dq",       32'(tr_dq[4]),   32'hDEAD);
    check("wr_hi_we",       32'(tr_we[4]),   32'd0);
    we_low = 0;
    for (int k = 1; k <= ncyc; k++) if (!tr_we[k]) we_low++;
    check("wr_we_low_cycles", we_low, 32'd2);

    // Port 1 reads back the same word
    do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0);

    // Wrap of the high halfword to halfword address 0
    do_txn(1'b0, 1'b1, 32'h0007_FFFE, 32'h1234_5678, 0);
    check("wrap_lo_addr", 32'(tr_addr[2]), 32'h3FFFF);
    check("wrap_lo_dq",   32'(tr_dq[2]),   32'h5678);
    check("wrap_hi_addr", 32'(tr_addr[4]), 32'h00000);
    check("wrap_hi_dq",   32'(tr_dq[4]),   32'h1234);
    do_txn(1'b1, 1'b0, 32'h0007_FFFE, 32'h0, 0);

    // Both ports request continuously
    a0 = 32'h0000_0100;
    a1 = 32'h0007_FFFE;
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      win = ~last_srv;
`else
      win = 1'b0;
`endif
      last_srv = win;
      e.port  = win;
      e.is_rd = 1'b1;
      e.data  = win ? ref_word(a1) : ref_word(a0);
      exp_q.push_back(e);
    end
    bus.wr0 = 1'b0; bus.addr0 = a0;
    bus.wr1 = 1'b0; bus.addr1 = a1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) cnt++;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contention_grants", cnt, 32'd4);
    @(negedge clk);

    // req0 dropped in LO_ACC: transaction still completes
    do_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2);
    check("busy_after_drop", 32'(bus.busy), 32'd0);

    // Reset in HI_SET of a write aborts it
    bus.wr0 = 1'b1; bus.addr0 = 32'h0000_0200; bus.wdata0 = 32'hCAFE_F00D;
    bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_pre_addr", 32'(sram_addr), 32'h101);
    rst = 1'b0;
    bus.req0 = 1'b0;
    #1;
    check("abort_we_n",  32'(sram_we_n), 32'd1);
    check("abort_oe_n",  32'(sram_oe_n), 32'd1);
    check("abort_ce_n",  32'(sram_ce_n), 32'd1);
    check("abort_busy",  32'(bus.busy), 32'd0);
    check("abort_done",  {30'd0, bus.done1, bus.done0}, 32'd0);
    check("abort_addr",  32'(sram_addr), 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    ref_hw[lo_idx(32'h0000_0200)] = 16'hF00D;
    last_srv = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 0);

    // Randomized single-port traffic
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 1) != 0) ? 32'h0007_FFC0 : 32'h0000_0100;
      a = a + 32'($urandom_range(0, 63));
      a = a | ($urandom & 32'hFFF8_0000);
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
